// File: rtl/led_pattern_sequencer_if.sv
// ============================================================================
// Module   : led_pattern_sequencer_if
// Brief    : Host-side mode/speed controls and LED/status outputs of the sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface led_pattern_sequencer_if;
    logic       MODE_REQ;
    logic [1:0] MODE_SEL;
    logic [1:0] SPEED;
    logic       PAUSE;
    logic [7:0] LED;
    logic       TICK;
    logic       BUSY;
    logic       MODE_ACK;

    modport master (
        output MODE_REQ, MODE_SEL, SPEED, PAUSE,
        input  LED, TICK, BUSY, MODE_ACK
    );

    modport slave (
        input  MODE_REQ, MODE_SEL, SPEED, PAUSE,
        output LED, TICK, BUSY, MODE_ACK
    );
endinterface

`default_nettype wire

// File: rtl/led_pattern_sequencer.sv
// ============================================================================
// Module   : led_pattern_sequencer
// Brief    : Prescaler -> speed sub-divider -> pattern FSM driving 8 LEDs, with
//            step-aligned mode-change handshake. Optional macro: CHASE_BOUNCE_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module led_pattern_sequencer #(
    parameter int CLK_HZ  = 40000000,
    parameter int TICK_HZ = 8
) (
    input  wire logic               CLK,
    input  wire logic               RESET,
    led_pattern_sequencer_if.slave  bus
);

    localparam int DIV_MAX = CLK_HZ / TICK_HZ - 1;
    localparam int CNT_W   = (DIV_MAX < 2) ? 1 : $clog2(DIV_MAX + 1);
    localparam logic [CNT_W-1:0] C_DIV_MAX = CNT_W'(DIV_MAX);

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_BLINK = 2'd1,
        S_CHASE = 2'd2,
        S_FILL  = 2'd3
    } mode_e;

    logic [CNT_W-1:0] pre_q, pre_d;
    logic             tick_q, tick_d;
    logic [2:0]       sub_q, sub_d;
    logic [2:0]       sub_lim;
    logic             w_tick, w_step;

    mode_e            state_q, state_d;
    mode_e            pend_q, pend_d;
    logic [7:0]       led_q, led_d;
    logic             busy_q, busy_d;
    logic             ack_q, ack_d;
`ifdef CHASE_BOUNCE_EN
    logic             dir_q, dir_d;
`endif

    // A pending tick is held (not dropped) across PAUSE so the run resumes exactly.
    always_comb begin
        pre_d  = pre_q;
        tick_d = tick_q;
        if (!bus.PAUSE) begin
            tick_d = (pre_q == C_DIV_MAX);
            pre_d  = (pre_q == C_DIV_MAX) ? '0 : pre_q + 1'b1;
        end
        sub_lim = 3'((4'd1 << bus.SPEED) - 4'd1);
        w_tick  = tick_q & ~bus.PAUSE;
        w_step  = w_tick & (sub_q >= sub_lim);
        sub_d   = sub_q;
        if (w_tick) begin
            sub_d = w_step ? 3'd0 : sub_q + 3'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        led_d   = led_q;
        busy_d  = busy_q;
        ack_d   = 1'b0;
`ifdef CHASE_BOUNCE_EN
        dir_d   = dir_q;
`endif
        if (bus.MODE_REQ && !busy_q) begin
            pend_d = mode_e'(bus.MODE_SEL);
            busy_d = 1'b1;
        end
        if (w_step) begin
            if (busy_q) begin
                // Mode switch consumes this step: load the entry value, no advance.
                state_d = pend_q;
                busy_d  = 1'b0;
                ack_d   = 1'b1;
`ifdef CHASE_BOUNCE_EN
                dir_d   = 1'b0;
`endif
                case (pend_q)
                    S_BLINK: led_d = 8'hFF;
                    S_CHASE: led_d = 8'h01;
                    default: led_d = 8'h00;
                endcase
            end else begin
                case (state_q)
                    S_BLINK: led_d = ~led_q;
                    S_CHASE: begin
`ifdef CHASE_BOUNCE_EN
                        if (!dir_q) begin
                            if (led_q[7]) begin
                                led_d = 8'h40;
                                dir_d = 1'b1;
                            end else begin
                                led_d = {led_q[6:0], 1'b0};
                            end
                        end else begin
                            if (led_q[0]) begin
                                led_d = 8'h02;
                                dir_d = 1'b0;
                            end else begin
                                led_d = {1'b0, led_q[7:1]};
                            end
                        end
`else
                        led_d = {led_q[6:0], led_q[7]};
`endif
                    end
                    S_FILL:  led_d = (led_q == 8'hFF) ? 8'h00 : {led_q[6:0], 1'b1};
                    default: led_d = 8'h00;
                endcase
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pre_q   <= '0;
            tick_q  <= 1'b0;
            sub_q   <= 3'd0;
            state_q <= S_OFF;
            pend_q  <= S_OFF;
            led_q   <= 8'h00;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
`ifdef CHASE_BOUNCE_EN
            dir_q   <= 1'b0;
`endif
        end else begin
            pre_q   <= pre_d;
            tick_q  <= tick_d;
            sub_q   <= sub_d;
            state_q <= state_d;
            pend_q  <= pend_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
`ifdef CHASE_BOUNCE_EN
            dir_q   <= dir_d;
`endif
        end
    end

    assign bus.LED      = led_q;
    assign bus.TICK     = w_tick;
    assign bus.BUSY     = busy_q;
    assign bus.MODE_ACK = ack_q;

endmodule

`default_nettype wire

// File: tb/tb_led_pattern_sequencer.sv
// ============================================================================
// Module   : tb_led_pattern_sequencer
// Brief    : Randomized bench for led_pattern_sequencer against a pattern-index model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_led_pattern_sequencer;

    localparam int CLK_HZ  = 16;
    localparam int TICK_HZ = 4;
    localparam int DIV_MAX = CLK_HZ / TICK_HZ - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    led_pattern_sequencer_if bus();

    led_pattern_sequencer #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) dut (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: mode plus an index into that mode's sequence since entry.
    int m_pc   = 0;
    int m_sub  = 0;
    int m_idx  = 0;
    int m_mode = 0;
    int m_pend = 0;
    bit m_tick = 1'b0;
    bit m_busy = 1'b0;
    bit m_ack  = 1'b0;

    function automatic logic [7:0] pat(int mode, int idx);
        int p;
        case (mode)
            1: return (idx % 2 == 0) ? 8'hFF : 8'h00;
            2: begin
`ifdef CHASE_BOUNCE_EN
                p = idx % 14;
                return (p < 8) ? 8'(1 << p) : 8'(1 << (14 - p));
`else
                p = idx % 8;
                return 8'(1 << p);
`endif
            end
            3: begin
                p = idx % 9;
                return 8'((1 << p) - 1);
            end
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [10:0] exp_out();
        return {pat(m_mode, m_idx), m_tick && !bus.PAUSE, m_busy, m_ack};
    endfunction

    always @(negedge rst_n) begin
        m_pc = 0; m_sub = 0; m_idx = 0; m_mode = 0; m_pend = 0;
        m_tick = 1'b0; m_busy = 1'b0; m_ack = 1'b0;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            bit eff, stp, old_busy;
            int lim;
            eff      = m_tick && !bus.PAUSE;
            lim      = (1 << bus.SPEED) - 1;
            stp      = eff && (m_sub >= lim);
            old_busy = m_busy;
            if (!bus.PAUSE) begin
                m_tick = (m_pc == DIV_MAX);
                m_pc   = (m_pc == DIV_MAX) ? 0 : m_pc + 1;
            end
            if (eff) m_sub = stp ? 0 : m_sub + 1;
            m_ack = 1'b0;
            if (bus.MODE_REQ && !old_busy) begin
                m_pend = int'(bus.MODE_SEL);
                m_busy = 1'b1;
            end
            if (stp) begin
                if (old_busy) begin
                    m_mode = m_pend; m_idx = 0; m_busy = 1'b0; m_ack = 1'b1;
                end else begin
                    m_idx++;
                end
            end
        end
    end

    task automatic test_reset();
        logic [10:0] obs;
        bus.MODE_REQ = 1'b0; bus.MODE_SEL = 2'd0; bus.SPEED = 2'd0; bus.PAUSE = 1'b0;
        repeat (3) @(negedge clk);
        obs = {bus.LED, bus.TICK, bus.BUSY, bus.MODE_ACK};
        checks++;
        if (obs !== 11'd0) begin
            errors++; $display("FAIL reset_state got=%h exp=%h", obs, 11'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            obs = {bus.LED, bus.TICK, bus.BUSY, bus.MODE_ACK};
            checks++;
            if (obs !== exp_out()) begin
                errors++; $display("FAIL idle cyc=%0d got=%h exp=%h", i, obs, exp_out());
            end
        end
    endtask

    task automatic test_blink();
        logic [10:0] obs;
        for (int i = 0; i < 40; i++) begin
            bus.MODE_REQ = (i == 0); bus.MODE_SEL = 2'd1; bus.SPEED = 2'd0;
            @(negedge clk);
            obs = {bus.LED, bus.TICK, bus.BUSY, bus.MODE_ACK};
            checks++;
            if (obs !== exp_out()) begin
                errors++; $display("FAIL blink cyc=%0d got=%h exp=%h", i, obs, exp_out());
            end
        end
        bus.MODE_REQ = 1'b0;
    endtask

    task automatic test_chase();
        logic [10:0] obs;
        for (int i = 0; i < 280; i++) begin
            bus.MODE_REQ = (i == 0); bus.MODE_SEL = 2'd2; bus.SPEED = 2'd2;
            @(negedge clk);
            obs = {bus.LED, bus.TICK, bus.BUSY, bus.MODE_ACK};
            checks++;
            if (obs !== exp_out()) begin
                errors++; $display("FAIL chase cyc=%0d got=%h exp=%h", i, obs, exp_out());
            end
        end
        bus.MODE_REQ = 1'b0;
    endtask

    task automatic test_fill_ignore_second_req();
        logic [10:0] obs;
        for (int i = 0; i < 200; i++) begin
            bus.MODE_REQ = (i == 0) || (i == 2);
            bus.MODE_SEL = (i == 2) ? 2'd1 : 2'd3;
            bus.SPEED    = 2'd1;
            @(negedge clk);
            obs = {bus.LED, bus.TICK, bus.BUSY, bus.MODE_ACK};
            checks++;
            if (obs !== exp_out()) begin
                errors++; $display("FAIL fill cyc=%0d got=%h exp=%h", i, obs, exp_out());
            end
        end
        bus.MODE_REQ = 1'b0;
    endtask

    task automatic test_pause();
        logic [10:0] obs;
        for (int i = 0; i < 130; i++) begin
            bus.MODE_REQ = (i == 0); bus.MODE_SEL = 2'd2; bus.SPEED = 2'd1;
            bus.PAUSE    = (i >= 50) && (i < 70);
            @(negedge clk);
            obs = {bus.LED, bus.TICK, bus.BUSY, bus.MODE_ACK};
            checks++;
            if (obs !== exp_out()) begin
                errors++; $display("FAIL pause cyc=%0d got=%h exp=%h", i, obs, exp_out());
            end
        end
        bus.MODE_REQ = 1'b0; bus.PAUSE = 1'b0;
    endtask

    task automatic test_random();
        logic [10:0] obs;
        for (int i = 0; i < 800; i++) begin
            bus.MODE_REQ = ($urandom_range(0, 7) == 0);
            bus.MODE_SEL = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) bus.SPEED = 2'($urandom_range(0, 3));
            bus.PAUSE    = ($urandom_range(0, 9) == 0);
            @(negedge clk);
            obs = {bus.LED, bus.TICK, bus.BUSY, bus.MODE_ACK};
            checks++;
            if (obs !== exp_out()) begin
                errors++; $display("FAIL random cyc=%0d got=%h exp=%h", i, obs, exp_out());
            end
        end
        bus.MODE_REQ = 1'b0; bus.PAUSE = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [10:0] obs;
        bus.SPEED = 2'd0;
        for (int i = 0; i < 40; i++) begin
            bus.MODE_REQ = (i == 0); bus.MODE_SEL = 2'd3;
            @(negedge clk);
        end
        bus.MODE_REQ = 1'b1; bus.MODE_SEL = 2'd1;
        @(negedge clk);
        bus.MODE_REQ = 1'b0;
        checks++;
        if (bus.BUSY !== 1'b1) begin
            errors++; $display("FAIL pre_reset_busy got=%b exp=1", bus.BUSY);
        end
        #2 rst_n = 1'b0;
        #1;
        obs = {bus.LED, bus.TICK, bus.BUSY, bus.MODE_ACK};
        checks++;
        if (obs !== 11'd0) begin
            errors++; $display("FAIL async_reset got=%h exp=%h", obs, 11'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            obs = {bus.LED, bus.TICK, bus.BUSY, bus.MODE_ACK};
            checks++;
            if (obs !== exp_out()) begin
                errors++; $display("FAIL post_reset cyc=%0d got=%h exp=%h", i, obs, exp_out());
            end
        end
    endtask

    initial begin
        test_reset();
        test_blink();
        test_chase();
        test_fill_ignore_second_req();
        test_pause();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
